// File: rtl/stage_monitor.sv
// ---------------------------------------------------------------------------
// stage_monitor
//
// Watches the write-enable strobes of the multi-cycle stage sequencer and
// checks that they follow the nine-phase order IF, IF_ID, ID, ID_EX, EX_MEM,
// MEM, MEM_WB, WB, WB_IF. When a cycle breaks the expected pattern, the
// violation is reported one cycle later. The monitor then drops to UNLOCKED
// until it can resynchronise on an isolated if_id_wren.
//
// Ports:
//   clk, reset_n        clock and synchronous active-low reset
//   stage_reset_n       sequencer run indicator (low = sequencer in INIT)
//   *_wren              stage strobes, sampled every cycle
//   clr_counters        synchronous clear of counters and err_sticky
//   phase, locked       tracked phase (15 = UNLOCKED) and lock status
//   err_pulse           one-cycle pulse per violation
//   err_code, err_phase classification and expected phase of last violation
//   err_sticky          set on any violation until reset/clear
//   instr_count         completed instruction cycles (wraps)
//   cycle_count         cycles sampled with stage_reset_n high (wraps)
//   err_count           violations counted (saturates)
// ---------------------------------------------------------------------------
module stage_monitor #(
    parameter int CNT_W = 32,
    parameter int ERR_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stage_reset_n,
    input  logic             pc_wren,
    input  logic             wb_if_wren,
    input  logic             if_id_wren,
    input  logic             id_ex_wren,
    input  logic             ex_mem_wren,
    input  logic             mem_wb_wren,
    input  logic             ram_wren,
    input  logic             reg_wren,
    input  logic             clr_counters,
    output logic [3:0]       phase,
    output logic             locked,
    output logic             err_pulse,
    output logic [1:0]       err_code,
    output logic [3:0]       err_phase,
    output logic             err_sticky,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] cycle_count,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [3:0] {
        PH_IF       = 4'd0,
        PH_IF_ID    = 4'd1,
        PH_ID       = 4'd2,
        PH_ID_EX    = 4'd3,
        PH_EX_MEM   = 4'd4,
        PH_MEM      = 4'd5,
        PH_MEM_WB   = 4'd6,
        PH_WB       = 4'd7,
        PH_WB_IF    = 4'd8,
        PH_UNLOCKED = 4'd15
    } phase_e;

    // Strobe bit positions inside the packed strobe vector.
    localparam logic [7:0] ST_PC     = 8'h01;
    localparam logic [7:0] ST_WB_IF  = 8'h02;
    localparam logic [7:0] ST_IF_ID  = 8'h04;
    localparam logic [7:0] ST_ID_EX  = 8'h08;
    localparam logic [7:0] ST_EX_MEM = 8'h10;
    localparam logic [7:0] ST_MEM_WB = 8'h20;
    localparam logic [7:0] ST_RAM    = 8'h40;
    localparam logic [7:0] ST_REG    = 8'h80;

    phase_e             phase_q, phase_d;
    logic               locked_q, locked_d;
    logic               err_pulse_q, err_pulse_d;
    logic [1:0]         err_code_q, err_code_d;
    logic [3:0]         err_phase_q, err_phase_d;
    logic               err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0]   instr_q, instr_d;
    logic [CNT_W-1:0]   cycle_q, cycle_d;
    logic [ERR_W-1:0]   err_count_q, err_count_d;

    logic [7:0]         strobes;
    logic [7:0]         expected;
    logic [7:0]         allowed;
    logic               multiHit;
    logic               missingHit;
    logic               extraHit;
    logic [1:0]         violCode;

    assign strobes = {reg_wren, ram_wren, mem_wb_wren, ex_mem_wren,
                      id_ex_wren, if_id_wren, wb_if_wren, pc_wren};

    // Expected strobe for the current phase. pc_wren is tolerated only as a
    // companion in WB_IF, so it widens the allowed set there but is never
    // itself the strobe whose absence counts as missing.
    always_comb begin
        expected = 8'h00;
        case (phase_q)
            PH_IF_ID:  expected = ST_IF_ID;
            PH_ID_EX:  expected = ST_ID_EX;
            PH_EX_MEM: expected = ST_EX_MEM;
            PH_MEM:    expected = ST_RAM;
            PH_MEM_WB: expected = ST_MEM_WB;
            PH_WB:     expected = ST_REG;
            PH_WB_IF:  expected = ST_WB_IF;
            default:   expected = 8'h00;
        endcase
    end

    assign allowed    = expected | ((phase_q == PH_WB_IF) ? ST_PC : 8'h00);
    assign multiHit   = ($countones(strobes) > 1) &&
                        !((phase_q == PH_WB_IF) && (strobes == (ST_PC | ST_WB_IF)));
    assign missingHit = (expected != 8'h00) && ((strobes & expected) == 8'h00);
    assign extraHit   = (strobes & ~allowed) != 8'h00;
    assign violCode   = multiHit   ? 2'd3 :
                        missingHit ? 2'd2 :
                        extraHit   ? 2'd1 : 2'd0;

    // Next-state logic: tracking, checking, error capture and counters.
    // clr_counters is applied last so it beats any same-cycle increment,
    // while a same-cycle violation can still re-arm err_sticky.
    always_comb begin
        phase_d      = phase_q;
        locked_d     = locked_q;
        err_pulse_d  = 1'b0;
        err_code_d   = err_code_q;
        err_phase_d  = err_phase_q;
        err_sticky_d = err_sticky_q;
        instr_d      = instr_q;
        cycle_d      = cycle_q;
        err_count_d  = err_count_q;

        if (!stage_reset_n) begin
            phase_d  = PH_IF;
            locked_d = 1'b1;
        end else begin
            cycle_d = cycle_q + 1'b1;
            if (phase_q == PH_UNLOCKED) begin
                if (strobes == ST_IF_ID) begin
                    phase_d  = PH_ID;
                    locked_d = 1'b1;
                end
            end else if (violCode != 2'd0) begin
                phase_d      = PH_UNLOCKED;
                locked_d     = 1'b0;
                err_pulse_d  = 1'b1;
                err_code_d   = violCode;
                err_phase_d  = phase_q;
                err_sticky_d = 1'b1;
                if (err_count_q != {ERR_W{1'b1}}) begin
                    err_count_d = err_count_q + 1'b1;
                end
            end else if (phase_q == PH_WB_IF) begin
                phase_d = PH_IF;
                instr_d = instr_q + 1'b1;
            end else begin
                phase_d = phase_e'(phase_q + 4'd1);
            end
        end

        if (clr_counters) begin
            instr_d      = '0;
            cycle_d      = '0;
            err_count_d  = '0;
            err_sticky_d = err_pulse_d;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase_q      <= PH_IF;
            locked_q     <= 1'b1;
            err_pulse_q  <= 1'b0;
            err_code_q   <= 2'd0;
            err_phase_q  <= 4'd0;
            err_sticky_q <= 1'b0;
            instr_q      <= '0;
            cycle_q      <= '0;
            err_count_q  <= '0;
        end else begin
            phase_q      <= phase_d;
            locked_q     <= locked_d;
            err_pulse_q  <= err_pulse_d;
            err_code_q   <= err_code_d;
            err_phase_q  <= err_phase_d;
            err_sticky_q <= err_sticky_d;
            instr_q      <= instr_d;
            cycle_q      <= cycle_d;
            err_count_q  <= err_count_d;
        end
    end

    assign phase       = phase_q;
    assign locked      = locked_q;
    assign err_pulse   = err_pulse_q;
    assign err_code    = err_code_q;
    assign err_phase   = err_phase_q;
    assign err_sticky  = err_sticky_q;
    assign instr_count = instr_q;
    assign cycle_count = cycle_q;
    assign err_count   = err_count_q;

endmodule
